// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam int BCD_NIBBLE = 4;

  // Smallest width w with 2**w >= 10**n, i.e. enough for n nines.
  function automatic int min_bin_w(input int n);
    longint p;
    longint one;
    int w;
    p = 1;
    one = 1;
    w = 0;
    for (int i = 0; i < n; i++) p = p * 10;
    while ((one << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One decimal step: acc*10 + d, plus a flag for a non-decimal nibble.
module bcd_mac10 #(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       d,
  output logic [BIN_W-1:0] acc_next,
  output logic             digit_bad
);

  // Modular arithmetic: working in BIN_W bits equals truncating a wider sum.
  assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(d);
  assign digit_bad = (d > 4'd9);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first,
// with valid/ready on both sides and an error flag for bad nibbles.
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  busy
);
  import bcd_pkg::*;

  localparam int W  = BCD_NIBBLE * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_w
    $error("BIN_W too small for DIGITS");
  end

  bcd_state_t     state;
  logic [W-1:0]   sr;
  logic [BIN_W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           err_acc;

  logic [3:0]       d;
  logic [BIN_W-1:0] acc_next;
  logic             bad;
  logic             err_fin;
  logic             last;

  assign d       = sr[W-1 -: BCD_NIBBLE];
  assign err_fin = err_acc | bad;
  assign last    = (cnt == CW'(DIGITS - 1));

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc      (acc),
    .d        (d),
    .acc_next (acc_next),
    .digit_bad(bad)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state == CONV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      err_acc   <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr      <= bcd_in;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          acc <= acc_next;
          sr  <= sr << BCD_NIBBLE;
          cnt <= cnt + 1'b1;
          if (bad) err_acc <= 1'b1;
          if (last) begin
            bin_out <= err_fin ? '0 : acc_next;
            err     <= err_fin;
            state   <= DONE;
          end
        end
        DONE: begin
          // Results land on entry; valid follows one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
